// File: rtl/uart_spi_pkg.sv
// Shared types and helpers for the UART-to-SPI bridge.
package uart_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // cpol is bit 1 and cpha is bit 0, so a raw 2-bit spi_mode casts directly.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Wide enough for the largest half-period (16 clk cycles).
  localparam int HALF_W = 5;

  // SCLK half-period in clk cycles: 2, 4, 8 or 16.
  function automatic logic [HALF_W-1:0] half_period(input logic [1:0] freq_control);
    return HALF_W'(2) << freq_control;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count status.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage and pointers; the depth is a power of two so pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_spi_bridge.sv
// Bridge between a UART RX/TX word stream and an SPI master with
// selectable mode, rate and chip select.
module uart_spi_bridge
  import uart_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        freq_control,
  input  logic [1:0]        spi_mode,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              overflow
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  spi_state_t        state;
  spi_mode_t         mode_lat;
  logic [1:0]        fc_lat;
  logic [HALF_W-1:0] cnt;
  logic [HALF_W-1:0] half_m1;
  logic [BIT_W-1:0]  bit_cnt;
  logic              phase;
  logic [DATA_W-1:0] shift_tx;
  logic [DATA_W-1:0] shift_rx;
  logic [NUM_CS-1:0] cs_dec;

  logic              cnt_done;
  logic              last_bit;
  logic              lead_edge;
  logic              trail_edge;
  logic              out_edge;
  logic              sample_edge;
  logic              start;
  logic              rx_push;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic [CNT_W-1:0]  tx_count;
  logic              rx_full;
  logic              rx_empty;
  logic [CNT_W-1:0]  rx_count;
  logic              unused_fifo_status;

  assign unused_fifo_status = ^{tx_count, rx_count};

  // Starting only while the RX FIFO has room guarantees the final push of a
  // transaction can never be refused.
  assign start    = (state == IDLE) && !tx_empty && !rx_full;
  assign half_m1  = half_period(fc_lat) - HALF_W'(1);
  assign cnt_done = (cnt == half_m1);
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));

  // Leading edge leaves CPOL; the first one closes SETUP, later ones start each new bit.
  assign lead_edge   = cnt_done && ((state == SETUP) || ((state == SHIFT) && phase && !last_bit));
  assign trail_edge  = cnt_done && (state == SHIFT) && !phase;
  assign out_edge    = mode_lat.cpha ? lead_edge : trail_edge;
  assign sample_edge = mode_lat.cpha ? trail_edge : lead_edge;
  assign rx_push     = (state == HOLD) && cnt_done;

  assign uart_tx_valid = !rx_empty;

  // One-hot active-low decode of the live cs_sel; out-of-range indices select nothing.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  // Transaction sequencing, SCLK generation and chip-select/busy control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_lat <= '0;
      fc_lat   <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= '1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= spi_mode[1];
          cnt  <= '0;
          if (start) begin
            mode_lat <= spi_mode_t'(spi_mode);
            fc_lat   <= freq_control;
            cs_n     <= cs_dec;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sclk    <= ~mode_lat.cpol;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + HALF_W'(1);
          end
        end
        SHIFT: begin
          if (cnt_done) begin
            cnt <= '0;
            if (!phase) begin
              phase <= 1'b1;
              sclk  <= mode_lat.cpol;
            end else if (last_bit) begin
              state <= HOLD;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= bit_cnt + BIT_W'(1);
              sclk    <= ~mode_lat.cpol;
            end
          end else begin
            cnt <= cnt + HALF_W'(1);
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cnt   <= '0;
            cs_n  <= '1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + HALF_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MOSI/MISO shift registers; MOSI presents the MSB from SETUP onwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_tx <= '0;
      shift_rx <= '0;
      mosi     <= 1'b0;
    end else if (start) begin
      shift_tx <= tx_head;
      shift_rx <= '0;
      mosi     <= tx_head[DATA_W-1];
    end else if (state == IDLE) begin
      mosi <= 1'b0;
    end else begin
      if (out_edge) begin
        mosi     <= mode_lat.cpha ? shift_tx[DATA_W-1] : shift_tx[DATA_W-2];
        shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
      end
      if (sample_edge) begin
        shift_rx <= {shift_rx[DATA_W-2:0], miso};
      end
    end
  end

  // Sticky flag for UART words lost because the TX FIFO was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (uart_rx_valid && tx_full) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (uart_rx_valid),
    .push_data (uart_rx_data),
    .pop       (start),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (shift_rx),
    .pop       (uart_tx_ready),
    .head      (uart_tx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

endmodule

// File: doc/uart_spi_bridge.md
Name: uart_spi_bridge

Overview:
Parametrised successor to the UART/SPI loopback top. Words received by the UART RX are buffered in a TX FIFO and sent through an SPI master. The SPI master supports selectable mode and chip-select, and its word width is a parameter. Each word shifted in on MISO is buffered in an RX FIFO and presented to the UART TX as a valid/ready stream. The block sits between the existing uart_rx_tx core and the external SPI pins.

Parameters:
DATA_W, 8, SPI word and FIFO entry width (bits, >=2)
FIFO_DEPTH, 4, entries per FIFO (power of two, >=2)
NUM_CS, 2, number of chip-select outputs (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
freq_control  input  2  SCLK rate select
spi_mode  input  2  [1]=CPOL, [0]=CPHA
cs_sel  input  $clog2(NUM_CS) (min 1)  target slave index
uart_rx_data  input  DATA_W  word from UART RX
uart_rx_valid  input  1  one-cycle strobe, uart_rx_data valid
uart_tx_data  output  DATA_W  word to UART TX
uart_tx_valid  output  1  uart_tx_data valid
uart_tx_ready  input  1  UART TX accepts word
sclk  output  1  SPI clock
mosi  output  1  SPI data out
miso  input  1  SPI data in (pre-synchronised)
cs_n  output  NUM_CS  active-low chip selects
busy  output  1  SPI transaction in progress
overflow  output  1  sticky: RX word dropped on full TX FIFO

Behaviour:
- Reset (reset=0, async) values:
  - sclk=0, mosi=0, cs_n=all 1, busy=0, overflow=0.
  - uart_tx_valid=0, uart_tx_data=0.
  - Both FIFOs empty; FSM in IDLE.
- Half-period H = 2^(freq_control+1) clk cycles: fc 0/1/2/3 gives H = 2/4/8/16. SCLK period is 2H.
- TX FIFO push:
  - A uart_rx_valid strobe pushes uart_rx_data if the FIFO is not full at that cycle.
  - If full, the word is dropped and overflow is set. overflow clears only on reset.
- FIFO rules:
  - Simultaneous push and pop are allowed when the FIFO is neither empty nor full; count is unchanged.
  - A push to a full FIFO is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - sclk follows spi_mode[1] (registered).
  - Exits when the TX FIFO is non-empty AND the RX FIFO is not full.
  - On exit: pop the word into the shift register and latch spi_mode, freq_control and cs_sel for the whole transaction (later changes ignored). Assert cs_n[cs_sel]=0, set busy=1, go to SETUP.
- SETUP (H cycles): mosi = MSB of the word, then go to SHIFT.
- SHIFT (DATA_W bits, 2H cycles each, MSB first):
  - CPHA=0: sample miso on the leading edge; shift mosi on the trailing edge.
  - CPHA=1: shift mosi on the leading edge; sample miso on the trailing edge.
  - Leading edge = transition away from CPOL.
  - After the last edge, sclk rests at CPOL; go to HOLD.
- HOLD (H cycles): at the end, push the received word into the RX FIFO, deassert cs_n, set busy=0, return to IDLE.
  - Minimum gap between back-to-back transactions is 1 IDLE cycle.
- cs_sel >= NUM_CS: no cs_n asserted, but the transaction still runs and its received word is pushed.
- UART TX side:
  - uart_tx_valid = RX FIFO non-empty; uart_tx_data = RX FIFO head (registered, first-word-fall-through).
  - Pop on valid & ready; the next word appears the cycle after the pop.
- Back-pressure: with the RX FIFO full, no new transaction starts. The transaction in flight always completes; its push cannot fail because IDLE entry was gated on RX FIFO not full.
- Reset mid-transaction: immediate abort, all outputs to reset values, FIFO contents discarded.

Decomposition:
- Package uart_spi_pkg:
  - spi_state_t enum (IDLE, SETUP, SHIFT, HOLD).
  - spi_mode_t packed struct {cpol, cpha}.
  - Function half_period(freq_control).
- One sub-module: sync_fifo (DATA_W, FIFO_DEPTH, first-word-fall-through, full/empty/count). Instantiated twice.

Test Plan:
- Mode 0, fc=0, DATA_W=8, cs_sel=1: push 0xA5 while the slave returns 0x3C.
  - cs_n=2'b01; mosi shows 1,0,1,0,0,1,0,1 sampled on sclk rising edges.
  - sclk period 4 clk; uart_tx_data=0x3C with valid.
- Mode 3, fc=2: push 0x81.
  - sclk idles 1; data changes on falling edges and is sampled on rising edges; SCLK period 16 clk.
  - Slave echo 0x81 returns on uart_tx_data.
- Fill: 6 rx strobes with the SPI slave stalling (uart_tx_ready=0, RX FIFO pre-filled to 4).
  - TX FIFO accepts 4 words; overflow=1 after the 5th strobe; busy stays 0.
- Back-to-back: push 3 words with uart_tx_ready=1.
  - Three transactions, each gap of 1 IDLE cycle.
  - Outputs arrive in order; cs_n is high for at least 1 cycle between transactions.
- Assert reset for 1 cycle during bit 4 of SHIFT.
  - sclk=0, cs_n=all 1, busy=0, uart_tx_valid=0 immediately; no word is pushed.
- Change spi_mode and cs_sel during SHIFT.
  - The ongoing transfer is unaffected; the next transaction uses the new values.
